// File: rtl/uart_rx_sipo_pkg.sv
// Shared UART receive definitions: parity codes, FSM encoding, frame config and parity check.
package uart_rx_sipo_pkg;

   localparam int OVERSAMPLE_DEF = 16;

   localparam logic [1:0] PAR_NONE0 = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_EVEN  = 2'b10;
   localparam logic [1:0] PAR_NONE1 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   typedef struct packed {
      logic [1:0] parity_type;
      logic       stop_bits;
      logic       data_length;
   } rx_cfg_t;

   function automatic logic parity_enabled(input logic [1:0] ptype);
      return !((ptype == PAR_NONE0) || (ptype == PAR_NONE1));
   endfunction

   // Unused upper data bits are held at 0, so an 8-bit XOR also covers 7-bit frames.
   function automatic logic parity_err(input logic [1:0] ptype, input logic [7:0] data,
                                       input logic pbit);
      logic result;
      result = 1'b0;
      case (ptype)
         PAR_ODD:  result = ~((^data) ^ pbit);
         PAR_EVEN: result = (^data) ^ pbit;
         default:  result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: 16x oversampled start detect, LSB-first data shift, parity and stop checks.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low sample on a baud tick
// ST_START  | counting to mid start bit to confirm or reject the start
// ST_DATA   | sampling data bits mid-bit, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling 1 or 2 stop bits, then publishing the byte
// ST_BREAK  | all-zero frame with bad stop: wait for the line to return high
module uart_rx_sipo
   import uart_rx_sipo_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick,
   input  logic       rx_in,
   input  logic [1:0] parity_type,
   input  logic       stop_bits,
   input  logic       data_length,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       framing_error,
   output logic       rx_active,
   output logic       rx_done
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   logic          rx_s;
   rx_state_t     state;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic          stop_cnt;
   logic [7:0]    shift_reg;
   rx_cfg_t       cfg_q;
   logic          par_err_q;
   logic          frm_err_q;
   logic          frm_err_nxt;
   logic          bit_mid;
   logic [2:0]    last_bit;

   uart_rx_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   assign bit_mid     = (tick_cnt == TICK_LAST);
   assign last_bit    = cfg_q.data_length ? 3'd7 : 3'd6;
   assign frm_err_nxt = frm_err_q | ~rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         tick_cnt      <= '0;
         bit_cnt       <= '0;
         stop_cnt      <= 1'b0;
         shift_reg     <= '0;
         cfg_q         <= '0;
         par_err_q     <= 1'b0;
         frm_err_q     <= 1'b0;
         data_out      <= '0;
         rx_valid      <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         rx_active     <= 1'b0;
         rx_done       <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         if (baud_tick) begin
            case (state)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state     <= ST_START;
                     tick_cnt  <= '0;
                     bit_cnt   <= '0;
                     stop_cnt  <= 1'b0;
                     shift_reg <= '0;
                     par_err_q <= 1'b0;
                     frm_err_q <= 1'b0;
                     cfg_q     <= '{parity_type: parity_type, stop_bits: stop_bits,
                                    data_length: data_length};
                  end
               end

               ST_START: begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     if (!rx_s) begin
                        state     <= ST_DATA;
                        rx_active <= 1'b1;
                        rx_done   <= 1'b0;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               ST_DATA: begin
                  if (bit_mid) begin
                     tick_cnt           <= '0;
                     shift_reg[bit_cnt] <= rx_s;
                     if (bit_cnt == last_bit) begin
                        bit_cnt <= '0;
                        state   <= parity_enabled(cfg_q.parity_type) ? ST_PARITY : ST_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               ST_PARITY: begin
                  if (bit_mid) begin
                     tick_cnt  <= '0;
                     par_err_q <= parity_err(cfg_q.parity_type, shift_reg, rx_s);
                     state     <= ST_STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               ST_STOP: begin
                  if (bit_mid) begin
                     tick_cnt  <= '0;
                     frm_err_q <= frm_err_nxt;
                     // Second stop bit is still sampled after a low first one; errors accumulate.
                     if (stop_cnt == cfg_q.stop_bits) begin
                        rx_valid      <= 1'b1;
                        data_out      <= shift_reg;
                        parity_error  <= par_err_q;
                        framing_error <= frm_err_nxt;
                        rx_active     <= 1'b0;
                        rx_done       <= 1'b1;
                        state         <= (frm_err_nxt && (shift_reg == 8'h00)) ? ST_BREAK
                                                                               : ST_IDLE;
                     end else begin
                        stop_cnt <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               ST_BREAK: begin
                  if (rx_s) begin
                     state <= ST_IDLE;
                  end
               end

               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
